// File: rtl/display_scan_ctrl.sv
// Seven-segment scan scheduler: time-slices one shared decoder across NUM_DIGITS
// displays with per-slot dead time and a double-buffered digit frame.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_DEAD | first DEAD_CYCLES cycles of a slot, all enables off
//   ST_ON   | remainder of the slot, enable of the current digit on
module display_scan_ctrl #(
    parameter int NUM_DIGITS  = 2,
    parameter int SLOT_CYCLES = 4096,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [3:0]              s,
    output logic [NUM_DIGITS-1:0]   en,
    output logic                    frame_done
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Slot timer counts down; slot position is SLOT_CYCLES-1-tmr_q.
    localparam logic [CW-1:0] TMR_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] TMR_ON1  = CW'(SLOT_CYCLES - DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           tmr_q, tmr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [3:0]              s_q, s_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lit;
`ifdef DISPLAY_SCAN_LZB_EN
    logic                    nz_above;
`endif

    always_comb begin
        slot_end = (tmr_q == '0);
        wrap     = slot_end && (idx_q == IDX_LAST);

        tmr_d = slot_end ? TMR_LAST : tmr_q - 1'b1;

        idx_d = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (slot_end) begin
            idx_d = idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_DEAD: if (tmr_q == TMR_ON1) state_d = ST_ON;
            ST_ON:   if (slot_end)         state_d = ST_DEAD;
        endcase

        pending_d    = load ? digits_in : pending_q;
        pend_valid_d = load | pend_valid_q;
        active_d     = active_q;
        // A load coinciding with the wrap bypasses the pending buffer.
        if (wrap) begin
            if (load) begin
                active_d     = digits_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                active_d     = pending_q;
                pend_valid_d = 1'b0;
            end
        end

        lit = '1;
`ifdef DISPLAY_SCAN_LZB_EN
        nz_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_above = nz_above | (|active_d[4*i +: 4]);
            lit[i]   = nz_above;
        end
`endif

        s_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                s_d = active_d[4*i +: 4];
            end
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            en_d[i] = (state_d == ST_ON) && (idx_d == IW'(i)) && lit[i];
        end

        frame_done_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DEAD;
            tmr_q        <= TMR_LAST;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            s_q          <= '0;
            en_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            s_q          <= s_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s          = s_q;
    assign en         = en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (2 digits, 16-cycle slots, 4 dead cycles): frames
// loaded into a scoreboard queue are compared against the scanned s/en output.
module tb_display_scan_ctrl;

    localparam int ND   = 2;
    localparam int SLOT = 16;
    localparam int DEAD = 4;
    localparam int FRM  = SLOT * ND;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    digits_in = '0;
    logic          load = 1'b0;
    logic [3:0]    s;
    logic [ND-1:0] en;
    logic          frame_done;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [7:0]    cur_exp = '0;
    logic [7:0]    sb_q[$];
    logic          mon_en = 1'b0;
    logic [3:0]    s_prev = '0;

    display_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SLOT_CYCLES(SLOT),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .load      (load),
        .s         (s),
        .en        (en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    // Invariants checked on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot0_en", 32'($onehot0(en)), 32'd1);
            if (s !== s_prev) chk("en_on_s_change", 32'(en), 32'd0);
        end
        s_prev <= s;
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        load  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b0;
        cyc     = 0;
        cur_exp = '0;
        sb_q.delete();
    endtask

    // Check outputs of the current cycle, then drive this cycle's inputs.
    task automatic step(input logic ld, input logic [7:0] din);
        int         cnt;
        int         slot;
        logic [1:0] exp_en;
        logic [3:0] exp_s;
        if (cyc > 0 && (cyc % FRM) == 0 && sb_q.size() > 0) cur_exp = sb_q.pop_front();
        cnt  = cyc % SLOT;
        slot = (cyc / SLOT) % ND;
        exp_s  = (slot == 0) ? cur_exp[3:0] : cur_exp[7:4];
        exp_en = (cnt < DEAD) ? 2'b00 : ((slot == 0) ? 2'b01 : 2'b10);
`ifdef DISPLAY_SCAN_LZB_EN
        if (slot == 1 && cur_exp[7:4] == 4'h0) exp_en = 2'b00;
`endif
        chk("en", 32'(en), 32'(exp_en));
        chk("s", 32'(s), 32'(exp_s));
        chk("frame_done", 32'(frame_done), 32'(cyc > 0 && (cyc % FRM) == 0));
        if (ld) begin
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            sb_q.push_back(din);
        end
        load      = ld;
        digits_in = din;
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1'b0, 8'h00);
    endtask

    initial begin
        int strobes;
        int budget;
        logic ld;

        // Reset and first scan
        do_reset(3);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        mon_en = 1'b1;
        run_to(3 * FRM + 2);

        // Double buffer: load at cycle 10 of digit 0's slot
        do_reset(2);
        run_to(10);
        step(1'b1, 8'hA5);
        run_to(2 * FRM + 4);

        // Last load wins, then load on the wrap edge
        run_to(2 * FRM + 6);
        step(1'b1, 8'h12);
        run_to(2 * FRM + 20);
        step(1'b1, 8'h34);
        run_to(4 * FRM - 1);
        step(1'b1, 8'h9C);
        run_to(5 * FRM + 2);

        // Random load strobes
        strobes = 0;
        budget  = 0;
        while (strobes < 1000 && budget < 20000) begin
            ld = ($urandom_range(0, 3) == 0);
            if (ld) strobes++;
            step(ld, 8'($urandom_range(0, 255)));
            budget++;
        end
        chk("random_strobes_done", 32'(strobes), 32'd1000);

        // Reset mid-operation with a load pending in digit 1's ON window
        do_reset(1);
        run_to(3);
        step(1'b1, 8'h5A);
        run_to(FRM + 20);
        step(1'b1, 8'hEE);
        run_to(FRM + 24);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        reset   = 1'b0;
        cyc     = 0;
        cur_exp = '0;
        sb_q.delete();
        run_to(3 * FRM);

        // Leading-zero cases: 07 then 00
        step(1'b1, 8'h07);
        run_to(6 * FRM);
        step(1'b1, 8'h00);
        run_to(9 * FRM);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
